// File: rtl/inv_cipher_ctrl_pkg.sv
// Shared types and constants for the AES inverse-cipher sequencer.
// The DRAIN state is present only when INV_CIPHER_CTRL_ABORT_EN is defined.
package inv_cipher_ctrl_pkg;

  typedef logic [127:0] block_t;

  localparam int AES_NR_128 = 10;
  localparam int AES_NR_192 = 12;
  localparam int AES_NR_256 = 14;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KREQ,
    ST_KADD,
    ST_RSTART,
    ST_RWAIT,
    ST_OUT
`ifdef INV_CIPHER_CTRL_ABORT_EN
    , ST_DRAIN
`endif
  } inv_ctrl_state_e;

  // True when the round counter value selects the last round, which skips InvMixColumns.
  function automatic logic is_final_round(input int unsigned rnd);
    return (rnd == 1);
  endfunction

endpackage

// File: rtl/inv_cipher_ctrl_if.sv
// Bundle of block-stream, key-store and round-core signals around the inverse-cipher sequencer.
// abort_i exists only when INV_CIPHER_CTRL_ABORT_EN is defined.
interface inv_cipher_ctrl_if #(
  parameter int RK_AW = 4
);
  import inv_cipher_ctrl_pkg::*;

  logic             in_valid_i;
  logic             in_ready_o;
  block_t           ct_i;
  logic             out_valid_o;
  logic             out_ready_i;
  block_t           pt_o;
  logic [RK_AW-1:0] rk_addr_o;
  block_t           rk_data_i;
  logic             rnd_start_o;
  block_t           rnd_s_o;
  logic             rnd_bypass_mc_o;
  block_t           rnd_s_i;
  logic             rnd_done_i;
  logic             busy_o;
`ifdef INV_CIPHER_CTRL_ABORT_EN
  logic             abort_i;
`endif

  // Controller side.
  modport slave (
`ifdef INV_CIPHER_CTRL_ABORT_EN
    input  abort_i,
`endif
    input  in_valid_i, ct_i, out_ready_i, rk_data_i, rnd_s_i, rnd_done_i,
    output in_ready_o, out_valid_o, pt_o, rk_addr_o, rnd_start_o, rnd_s_o,
           rnd_bypass_mc_o, busy_o
  );

  // Environment side: block source/sink, key store and round core.
  modport master (
`ifdef INV_CIPHER_CTRL_ABORT_EN
    output abort_i,
`endif
    output in_valid_i, ct_i, out_ready_i, rk_data_i, rnd_s_i, rnd_done_i,
    input  in_ready_o, out_valid_o, pt_o, rk_addr_o, rnd_start_o, rnd_s_o,
           rnd_bypass_mc_o, busy_o
  );

endinterface

// File: rtl/inv_cipher_ctrl.sv
// Sequencer for the T-table inverse round core: runs one full AES inverse cipher per block.
// Build option INV_CIPHER_CTRL_ABORT_EN adds abort_i and a DRAIN state.
module inv_cipher_ctrl
  import inv_cipher_ctrl_pkg::*;
#(
  parameter int NR    = AES_NR_128,
  parameter int RK_AW = 4
) (
  input  logic            clk,
  input  logic            rst,
  inv_cipher_ctrl_if.slave bus
);

  localparam logic [RK_AW-1:0] NR_IDX = RK_AW'(NR);

  inv_ctrl_state_e  state_q, state_d;
  block_t           st_q, st_d;
  logic [RK_AW-1:0] rnd_q, rnd_d;
  logic [RK_AW-1:0] rk_addr_q, rk_addr_d;
  logic             rnd_start;
  logic             bypass_mc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      st_q      <= '0;
      rnd_q     <= NR_IDX;
      rk_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      st_q      <= st_d;
      rnd_q     <= rnd_d;
      rk_addr_q <= rk_addr_d;
    end
  end

  // Keys are consumed NR down to 0; rnd is decremented on each start so that after the
  // round completes it already names the key for the following AddRoundKey.
  always_comb begin
    state_d   = state_q;
    st_d      = st_q;
    rnd_d     = rnd_q;
    rk_addr_d = rk_addr_q;
    rnd_start = 1'b0;
    bypass_mc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid_i && !rst) begin
          st_d      = bus.ct_i;
          rnd_d     = NR_IDX;
          rk_addr_d = NR_IDX;
          state_d   = ST_KREQ;
        end
      end
      ST_KREQ: state_d = ST_KADD;
      ST_KADD: begin
        st_d    = st_q ^ bus.rk_data_i;
        state_d = (rnd_q == '0) ? ST_OUT : ST_RSTART;
      end
      ST_RSTART: begin
        rnd_start = 1'b1;
        bypass_mc = is_final_round(32'(rnd_q));
        rnd_d     = rnd_q - RK_AW'(1);
        state_d   = ST_RWAIT;
      end
      ST_RWAIT: begin
        bypass_mc = (rnd_q == '0);
        if (bus.rnd_done_i) begin
          st_d      = bus.rnd_s_i;
          rk_addr_d = rnd_q;
          state_d   = ST_KREQ;
        end
      end
      ST_OUT: begin
        if (bus.out_ready_i) state_d = ST_IDLE;
      end
`ifdef INV_CIPHER_CTRL_ABORT_EN
      ST_DRAIN: begin
        if (bus.rnd_done_i) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase

`ifdef INV_CIPHER_CTRL_ABORT_EN
    // A round already in flight must finish before the core can be reused, hence DRAIN.
    if (bus.abort_i) begin
      case (state_q)
        ST_KREQ, ST_KADD, ST_OUT: state_d = ST_IDLE;
        ST_RSTART: begin
          rnd_start = 1'b0;
          state_d   = ST_IDLE;
        end
        ST_RWAIT: state_d = bus.rnd_done_i ? ST_IDLE : ST_DRAIN;
        default: ;
      endcase
    end
`endif
  end

  assign bus.in_ready_o      = (state_q == ST_IDLE) && !rst;
  assign bus.out_valid_o     = (state_q == ST_OUT);
  assign bus.busy_o          = (state_q != ST_IDLE);
  assign bus.pt_o            = st_q;
  assign bus.rnd_s_o         = st_q;
  assign bus.rk_addr_o       = rk_addr_q;
  assign bus.rnd_start_o     = rnd_start;
  assign bus.rnd_bypass_mc_o = bypass_mc;

endmodule

// File: tb/tb_inv_cipher_ctrl.sv
// Directed bench for inv_cipher_ctrl with a key-store RAM and an inverse-round core model.
// The abort scenario is built only when INV_CIPHER_CTRL_ABORT_EN is defined.
module tb_inv_cipher_ctrl;
  import inv_cipher_ctrl_pkg::*;

  localparam int NR    = 10;
  localparam int RK_AW = 4;

  localparam block_t KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam block_t CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam block_t PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam block_t KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam block_t CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam block_t PT_B   = 128'h3243f6a8885a308d313198a2e0370734;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  inv_cipher_ctrl_if #(.RK_AW(RK_AW)) bus ();

  inv_cipher_ctrl #(.NR(NR), .RK_AW(RK_AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] sbox  [256];
  logic [7:0] isbox [256];
  block_t     key_mem [16];
  int         lat_l = 4;
  int         cnt = 0;
  block_t     rnd_res = '0;
  logic       spur_done = 1'b0;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = '0; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  task automatic init_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = '0;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox[x]  = s;
      isbox[s] = 8'(x);
    end
  endtask

  function automatic block_t inv_mix(input block_t s);
    logic [7:0] a0, a1, a2, a3;
    block_t r;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8]; a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8]; a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = gmul(a0,8'h0e) ^ gmul(a1,8'h0b) ^ gmul(a2,8'h0d) ^ gmul(a3,8'h09);
      r[119-32*c -: 8] = gmul(a0,8'h09) ^ gmul(a1,8'h0e) ^ gmul(a2,8'h0b) ^ gmul(a3,8'h0d);
      r[111-32*c -: 8] = gmul(a0,8'h0d) ^ gmul(a1,8'h09) ^ gmul(a2,8'h0e) ^ gmul(a3,8'h0b);
      r[103-32*c -: 8] = gmul(a0,8'h0b) ^ gmul(a1,8'h0d) ^ gmul(a2,8'h09) ^ gmul(a3,8'h0e);
    end
    return r;
  endfunction

  // InvShiftRows + InvSubBytes, then InvMixColumns unless on the final round.
  function automatic block_t inv_round(input block_t s, input logic byp);
    block_t r;
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++)
        r[127-8*(4*c+row) -: 8] = isbox[s[127-8*(4*((c-row+4)%4)+row) -: 8]];
    return byp ? r : inv_mix(r);
  endfunction

  task automatic load_keys(input block_t key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    block_t      rk;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rcon, 24'h0};
        rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++) key_mem[r] = '0;
    for (int r = 0; r <= NR; r++) begin
      rk = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      key_mem[r] = (r == 0 || r == NR) ? rk : inv_mix(rk);
    end
  endtask

  // Sync-read key store and an inverse round core whose RWAIT lasts lat_l cycles.
  always @(posedge clk) begin
    if (rst) cnt <= 0;
    else if (bus.rnd_start_o) begin
      cnt     <= lat_l;
      rnd_res <= inv_round(bus.rnd_s_o, bus.rnd_bypass_mc_o);
    end else if (cnt != 0) cnt <= cnt - 1;
    bus.rk_data_i <= key_mem[bus.rk_addr_o];
  end
  assign bus.rnd_s_i    = rnd_res;
  assign bus.rnd_done_i = (cnt == 1) | spur_done;

  task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    n_vec++;
    assert (obs === exp_v)
    else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_reset_outputs(input string tag, input logic exp_ready);
    check_output({tag, " in_ready"},  bus.in_ready_o, exp_ready);
    check_output({tag, " out_valid"}, bus.out_valid_o, 0);
    check_output({tag, " busy"},      bus.busy_o, 0);
    check_output({tag, " start"},     bus.rnd_start_o, 0);
    check_output({tag, " bypass"},    bus.rnd_bypass_mc_o, 0);
    check_output({tag, " rk_addr"},   bus.rk_addr_o, 0);
    check_output({tag, " pt"},        bus.pt_o, 0);
    check_output({tag, " rnd_s"},     bus.rnd_s_o, 0);
  endtask

  task automatic apply_stimulus(input string tag, input block_t ct, input block_t exp_pt,
                                input int exp_lat, input int hold, input bit spur_kadd,
                                input int rst_pulse, input int abort_pulse);
    int n, starts, byp_n, byp_at, addr_n, drain, extra, ov;
    logic [RK_AW-1:0] addr_log [16];
    logic [RK_AW-1:0] last_addr;
    block_t held;
    bit stable, cut;
    starts = 0; byp_n = 0; byp_at = 0; cut = 0;
    for (int i = 0; i < 16; i++) addr_log[i] = 'x;
    @(negedge clk);
    check_output({tag, " accept ready"}, bus.in_ready_o, 1);
    bus.ct_i = ct; bus.in_valid_i = 1'b1;
    @(negedge clk);
    bus.in_valid_i = 1'b0; bus.ct_i = '0;
    n = 1; addr_log[0] = bus.rk_addr_o; addr_n = 1; last_addr = bus.rk_addr_o;
    while (!bus.out_valid_o && !cut && n < 400) begin
      spur_done = spur_kadd && (n == 2);
      if (n == 5) begin
        check_output({tag, " busy mid"},  bus.busy_o, 1);
        check_output({tag, " ready mid"}, bus.in_ready_o, 0);
      end
      if (bus.rnd_start_o) begin
        starts++;
        if (bus.rnd_bypass_mc_o) begin byp_n++; byp_at = starts; end
      end
      if (bus.rk_addr_o != last_addr) begin
        if (addr_n < 16) addr_log[addr_n] = bus.rk_addr_o;
        addr_n++; last_addr = bus.rk_addr_o;
      end
      if (rst_pulse > 0 && starts == rst_pulse && !bus.rnd_start_o) begin
        rst = 1'b1; cut = 1;
      end
`ifdef INV_CIPHER_CTRL_ABORT_EN
      else if (abort_pulse > 0 && starts == abort_pulse && !bus.rnd_start_o) begin
        bus.abort_i = 1'b1; cut = 1;
      end
`endif
      if (!cut) begin @(negedge clk); n++; end
    end
    spur_done = 1'b0;

    if (rst_pulse > 0) begin
      @(negedge clk);
      check_reset_outputs({tag, " mid-reset"}, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      check_output({tag, " ready after reset"}, bus.in_ready_o, 1);
      return;
    end
`ifdef INV_CIPHER_CTRL_ABORT_EN
    if (abort_pulse > 0) begin
      @(negedge clk);
      bus.abort_i = 1'b0;
      drain = 0; extra = 0; ov = 0;
      while (bus.busy_o && drain < 50) begin
        drain++;
        if (bus.rnd_start_o) extra++;
        if (bus.out_valid_o) ov++;
        @(negedge clk);
      end
      check_output({tag, " drain cycles"}, drain, 5);
      check_output({tag, " extra starts"}, extra, 0);
      check_output({tag, " out_valid seen"}, ov, 0);
      check_output({tag, " ready after drain"}, bus.in_ready_o, 1);
      return;
    end
`endif
    check_output({tag, " latency"}, n, exp_lat);
    check_output({tag, " pt"}, bus.pt_o, exp_pt);
    check_output({tag, " start pulses"}, starts, NR);
    check_output({tag, " bypass pulses"}, byp_n, 1);
    check_output({tag, " bypass on pulse"}, byp_at, NR);
    check_output({tag, " key count"}, addr_n, NR + 1);
    for (int i = 0; i <= NR; i++)
      check_output($sformatf("%s key%0d", tag, i), addr_log[i], NR - i);

    held = bus.pt_o; stable = 1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (bus.pt_o !== held || bus.out_valid_o !== 1'b1 || bus.in_ready_o !== 1'b0) stable = 0;
    end
    if (hold > 0) check_output({tag, " held stable"}, stable, 1);
    bus.out_ready_i = 1'b1;
    @(negedge clk);
    bus.out_ready_i = 1'b0;
    check_output({tag, " out_valid after"}, bus.out_valid_o, 0);
    check_output({tag, " busy after"},      bus.busy_o, 0);
    check_output({tag, " ready after"},     bus.in_ready_o, 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bus.in_valid_i  = 1'b0;
    bus.ct_i        = '0;
    bus.out_ready_i = 1'b0;
`ifdef INV_CIPHER_CTRL_ABORT_EN
    bus.abort_i     = 1'b0;
`endif
    init_sbox();
    load_keys(KEY_C1);

    repeat (2) @(negedge clk);
    check_reset_outputs("reset", 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check_output("idle ready", bus.in_ready_o, 1);

    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    check_output("spur idle busy",  bus.busy_o, 0);
    check_output("spur idle ready", bus.in_ready_o, 1);

    apply_stimulus("c1",    CT_C1, PT_C1, 73, 0,  1'b0, 0, 0);
    apply_stimulus("bp",    CT_C1, PT_C1, 73, 20, 1'b0, 0, 0);
    apply_stimulus("spur",  CT_C1, PT_C1, 73, 0,  1'b1, 0, 0);
    apply_stimulus("rst5",  CT_C1, PT_C1, 73, 0,  1'b0, 5, 0);
    load_keys(KEY_B);
    apply_stimulus("fipsb", CT_B,  PT_B,  73, 0,  1'b0, 0, 0);
`ifdef INV_CIPHER_CTRL_ABORT_EN
    load_keys(KEY_C1);
    lat_l = 6;
    apply_stimulus("abort", CT_C1, PT_C1, 93, 0,  1'b0, 0, 3);
    apply_stimulus("l6",    CT_C1, PT_C1, 93, 0,  1'b0, 0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
